// File: rtl/cpu_pkg.sv
// Shared CPU types for the register-file writeback path.
// Queue entry layout and the hardwired-zero register index.
package cpu_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] value;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Youngest-match search of queued writes for one register index.
// Entries are scanned oldest to youngest so the last match wins.
import cpu_pkg::*;

module wb_lookup #(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [4:0]               idx_i,
    output logic                     hit_o,
    output logic [31:0]              value_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Walk occupied slots from head; later (younger) hits overwrite
    always_comb begin
        hit_o   = 1'b0;
        value_o = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_i && idx_i != REG_ZERO &&
                entries_i[head_i + PW'(i)].rd == idx_i) begin
                hit_o   = 1'b1;
                value_o = entries_i[head_i + PW'(i)].value;
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// In-order writeback queue merging ALU and MDU results onto the
// register file write port, with forwarding lookups for rs/rt.
import cpu_pkg::*;

module writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_value,
    input  logic [31:0] alu_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_value,
    input  logic [31:0] mdu_pc,
    output logic        WriteEnable,
    output logic [4:0]  rd,
    output logic [31:0] WriteValue,
    output logic [31:0] PCvalue,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_hit,
    output logic [31:0] rs_value,
    output logic        rt_hit,
    output logic [31:0] rt_value
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          pop;
    logic [CW:0]   free;
    logic          mdu_acc, alu_acc;
    logic [PW-1:0] alu_ptr;
    wb_entry_t     head_e;

    assign pop    = (count_q != '0);
    assign head_e = mem_q[head_q];

    // The head slot is freed in the same cycle it drains
    assign free = (CW + 1)'(DEPTH) - {1'b0, count_q} + (CW + 1)'(pop);

    assign mdu_ready = (free >= (CW + 1)'(1));
    assign alu_ready = (free >= (CW + 1)'(2)) |
                       ((free >= (CW + 1)'(1)) & ~mdu_valid);

    assign mdu_acc = mdu_valid & mdu_ready;
    assign alu_acc = alu_valid & alu_ready;

    // MDU takes the older slot when both arrive together
    assign alu_ptr = tail_q + PW'(mdu_acc);

    assign head_d  = head_q + PW'(pop);
    assign tail_d  = tail_q + PW'(mdu_acc) + PW'(alu_acc);
    assign count_d = count_q - CW'(pop) + CW'(mdu_acc) + CW'(alu_acc);

    assign WriteEnable = pop;
    assign rd          = pop ? head_e.rd    : 5'd0;
    assign WriteValue  = pop ? head_e.value : 32'd0;
    assign PCvalue     = pop ? head_e.pc    : 32'd0;

    // Pointer/count update and entry capture; reset drops everything
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (mdu_acc) begin
                mem_q[tail_q] <= '{pc: mdu_pc, rd: mdu_rd, value: mdu_value};
            end
            if (alu_acc) begin
                mem_q[alu_ptr] <= '{pc: alu_pc, rd: alu_rd, value: alu_value};
            end
        end
    end

    wb_lookup #(.DEPTH(DEPTH)) u_rs_lookup (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .idx_i     (rs),
        .hit_o     (rs_hit),
        .value_o   (rs_value)
    );

    wb_lookup #(.DEPTH(DEPTH)) u_rt_lookup (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .idx_i     (rt),
        .hit_o     (rt_hit),
        .value_o   (rt_value)
    );

endmodule
